// File: rtl/tetron_move_controller_if.sv
// Spawn/move request handshake between the game sequencer and the move controller.
// The sequencer is the master, the controller is the slave.
interface tetron_move_controller_if;
  logic       spawn_valid;
  logic [2:0] spawn_type;
  logic       spawn_ready;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_ok;

  modport master (
    output spawn_valid, spawn_type, cmd_valid, cmd,
    input  spawn_ready, cmd_ready, cmd_done, cmd_ok
  );

  modport slave (
    input  spawn_valid, spawn_type, cmd_valid, cmd,
    output spawn_ready, cmd_ready, cmd_done, cmd_ok
  );
endinterface

// File: rtl/tetron_move_controller.sv
// Falling-block move controller.
// Each accepted spawn or move builds a trial position. That position is then
// checked cell by cell against the board walls and the occupancy read port.
// The controller commits the move, locks the piece, or raises game over.
//
// state | meaning
// IDLE  | waiting for spawn or move request
// SH0   | trial select presented to shapers, latency cycle 1
// SH1   | shaper latency cycle 2
// Ck    | range-check block k+1, issue board read if in range
// Wk    | board read data for block k+1 returns
// RES   | result cycle: cmd_done, cmd_ok, lock_valid
module tetron_move_controller (
  input  logic       clk,
  input  logic       rst_n,
  tetron_move_controller_if.slave mv,
  output logic [2:0] shaper_type_o,
  output logic [2:0] shaper_rotation_o,
  input  logic [4:0] blk1_voffset_i,
  input  logic [4:0] blk2_voffset_i,
  input  logic [4:0] blk3_voffset_i,
  input  logic [4:0] blk4_voffset_i,
  input  logic [4:0] blk1_hoffset_i,
  input  logic [4:0] blk2_hoffset_i,
  input  logic [4:0] blk3_hoffset_i,
  input  logic [4:0] blk4_hoffset_i,
  output logic       board_rd_en_o,
  output logic [4:0] board_rd_row_o,
  output logic [3:0] board_rd_col_o,
  input  logic       board_rd_occupied_i,
  output logic [4:0] pos_row_o,
  output logic [3:0] pos_col_o,
  output logic [2:0] rot_o,
  output logic [2:0] piece_type_o,
  output logic       piece_active_o,
  output logic       lock_valid_o,
  output logic       game_over_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_SH0, S_SH1, S_C0, S_W0, S_C1, S_W1, S_C2, S_W2, S_C3, S_W3, S_RES
  } state_t;

  localparam logic [1:0] CMD_LEFT  = 2'b00;
  localparam logic [1:0] CMD_RIGHT = 2'b01;
  localparam logic [1:0] CMD_ROT   = 2'b10;
  localparam logic [1:0] CMD_DOWN  = 2'b11;

  state_t      state_q, state_d;
  logic [5:0]  trial_row_q, trial_row_d;
  logic [5:0]  trial_col_q, trial_col_d;
  logic [1:0]  trial_rot_q, trial_rot_d;
  logic [2:0]  trial_type_q, trial_type_d;
  logic        op_spawn_q, op_spawn_d;
  logic [1:0]  op_cmd_q, op_cmd_d;
  logic        coll_q, coll_d;
  logic        rd_issued_q, rd_issued_d;
  logic [4:0]  pos_row_q, pos_row_d;
  logic [3:0]  pos_col_q, pos_col_d;
  logic [1:0]  rot_q, rot_d;
  logic [2:0]  type_q, type_d;
  logic        active_q, active_d;
  logic        game_over_q, game_over_d;

  logic        spawn_acc, cmd_acc;
  logic [4:0]  voff, hoff;
  logic signed [6:0] cell_row, cell_col;
  logic        out_of_range;
  logic        rd_en;

  assign spawn_acc = mv.spawn_valid && mv.spawn_ready;
  assign cmd_acc   = mv.cmd_valid && mv.cmd_ready && !spawn_acc;

  always_comb begin
    voff = blk1_voffset_i;
    hoff = blk1_hoffset_i;
    case (state_q)
      S_C1: begin voff = blk2_voffset_i; hoff = blk2_hoffset_i; end
      S_C2: begin voff = blk3_voffset_i; hoff = blk3_hoffset_i; end
      S_C3: begin voff = blk4_voffset_i; hoff = blk4_hoffset_i; end
      default: ;
    endcase
  end

  // Sums are widened to 7 bits so large offsets cannot wrap back into range.
  assign cell_row = $signed({trial_row_q[5], trial_row_q}) + $signed({2'b00, voff});
  assign cell_col = $signed({trial_col_q[5], trial_col_q}) + $signed({2'b00, hoff});
  assign out_of_range = (cell_row > 7'sd19) || (cell_row < 7'sd0) ||
                        (cell_col > 7'sd9)  || (cell_col < 7'sd0);

  always_comb begin
    state_d      = state_q;
    trial_row_d  = trial_row_q;
    trial_col_d  = trial_col_q;
    trial_rot_d  = trial_rot_q;
    trial_type_d = trial_type_q;
    op_spawn_d   = op_spawn_q;
    op_cmd_d     = op_cmd_q;
    coll_d       = coll_q;
    rd_issued_d  = rd_issued_q;
    pos_row_d    = pos_row_q;
    pos_col_d    = pos_col_q;
    rot_d        = rot_q;
    type_d       = type_q;
    active_d     = active_q;
    game_over_d  = game_over_q;
    rd_en        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (spawn_acc) begin
          trial_row_d  = 6'd0;
          trial_col_d  = 6'd4;
          trial_rot_d  = 2'd0;
          trial_type_d = mv.spawn_type;
          op_spawn_d   = 1'b1;
          coll_d       = 1'b0;
          state_d      = S_SH0;
        end else if (cmd_acc) begin
          trial_row_d  = {1'b0, pos_row_q};
          trial_col_d  = {2'b00, pos_col_q};
          trial_rot_d  = rot_q;
          trial_type_d = type_q;
          op_spawn_d   = 1'b0;
          op_cmd_d     = mv.cmd;
          coll_d       = 1'b0;
          state_d      = S_SH0;
          case (mv.cmd)
            CMD_LEFT:  trial_col_d = {2'b00, pos_col_q} - 6'd1;
            CMD_RIGHT: trial_col_d = {2'b00, pos_col_q} + 6'd1;
            CMD_ROT:   trial_rot_d = rot_q + 2'd1;
            default:   trial_row_d = {1'b0, pos_row_q} + 6'd1;
          endcase
        end
      end
      S_SH0: state_d = S_SH1;
      S_SH1: state_d = S_C0;
      S_C0, S_C1, S_C2, S_C3: begin
        if (out_of_range) begin
          coll_d      = 1'b1;
          rd_issued_d = 1'b0;
        end else begin
          rd_en       = 1'b1;
          rd_issued_d = 1'b1;
        end
        case (state_q)
          S_C0:    state_d = S_W0;
          S_C1:    state_d = S_W1;
          S_C2:    state_d = S_W2;
          default: state_d = S_W3;
        endcase
      end
      S_W0, S_W1, S_W2, S_W3: begin
        if (rd_issued_q && board_rd_occupied_i) coll_d = 1'b1;
        case (state_q)
          S_W0:    state_d = S_C1;
          S_W1:    state_d = S_C2;
          S_W2:    state_d = S_C3;
          default: state_d = S_RES;
        endcase
      end
      S_RES: begin
        state_d = S_IDLE;
        if (!coll_q) begin
          pos_row_d = trial_row_q[4:0];
          pos_col_d = trial_col_q[3:0];
          rot_d     = trial_rot_q;
          if (op_spawn_q) begin
            type_d   = trial_type_q;
            active_d = 1'b1;
          end
        end else if (op_spawn_q) begin
          game_over_d = 1'b1;
        end else if (op_cmd_q == CMD_DOWN) begin
          active_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      trial_row_q  <= '0;
      trial_col_q  <= '0;
      trial_rot_q  <= '0;
      trial_type_q <= '0;
      op_spawn_q   <= 1'b0;
      op_cmd_q     <= '0;
      coll_q       <= 1'b0;
      rd_issued_q  <= 1'b0;
      pos_row_q    <= '0;
      pos_col_q    <= '0;
      rot_q        <= '0;
      type_q       <= '0;
      active_q     <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      trial_row_q  <= trial_row_d;
      trial_col_q  <= trial_col_d;
      trial_rot_q  <= trial_rot_d;
      trial_type_q <= trial_type_d;
      op_spawn_q   <= op_spawn_d;
      op_cmd_q     <= op_cmd_d;
      coll_q       <= coll_d;
      rd_issued_q  <= rd_issued_d;
      pos_row_q    <= pos_row_d;
      pos_col_q    <= pos_col_d;
      rot_q        <= rot_d;
      type_q       <= type_d;
      active_q     <= active_d;
      game_over_q  <= game_over_d;
    end
  end

  // spawn_ready is gated by rst_n so every output reads 0 while reset is held.
  assign mv.spawn_ready = rst_n && (state_q == S_IDLE) && !active_q && !game_over_q;
  assign mv.cmd_ready   = (state_q == S_IDLE) && active_q;
  assign mv.cmd_done    = (state_q == S_RES);
  assign mv.cmd_ok      = (state_q == S_RES) && !coll_q;

  assign lock_valid_o   = (state_q == S_RES) && coll_q && !op_spawn_q && (op_cmd_q == CMD_DOWN);
  assign busy_o         = (state_q != S_IDLE);

  assign board_rd_en_o  = rd_en;
  assign board_rd_row_o = rd_en ? cell_row[4:0] : 5'd0;
  assign board_rd_col_o = rd_en ? cell_col[3:0] : 4'd0;

  assign shaper_type_o     = trial_type_q;
  assign shaper_rotation_o = {1'b0, trial_rot_q};

  assign pos_row_o      = pos_row_q;
  assign pos_col_o      = pos_col_q;
  assign rot_o          = {1'b0, rot_q};
  assign piece_type_o   = type_q;
  assign piece_active_o = active_q;
  assign game_over_o    = game_over_q;

endmodule

// File: tb/tb_tetron_move_controller.sv
// Directed bench for tetron_move_controller: board memory with registered read,
// fixed shaper offsets, hand-computed expectations per scenario.
module tb_tetron_move_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tetron_move_controller_if mv();

  logic [2:0] shaper_type, shaper_rotation;
  logic [4:0] v [4];
  logic [4:0] h [4];
  logic       board_rd_en;
  logic [4:0] board_rd_row;
  logic [3:0] board_rd_col;
  logic       occ_q;
  logic [4:0] pos_row;
  logic [3:0] pos_col;
  logic [2:0] rot, piece_type;
  logic       piece_active, lock_valid, game_over, busy;

  logic board [20][10];

  int n_cmp = 0;
  int n_err = 0;

  int   lat, rd_cnt, bad_rd, lock_cnt;
  bit   ready_seen;
  logic r_ok, r_lock;
  logic [4:0] r_pos_row;
  logic [2:0] r_sh_type, r_sh_rot;

  tetron_move_controller dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mv                  (mv),
    .shaper_type_o       (shaper_type),
    .shaper_rotation_o   (shaper_rotation),
    .blk1_voffset_i      (v[0]),
    .blk2_voffset_i      (v[1]),
    .blk3_voffset_i      (v[2]),
    .blk4_voffset_i      (v[3]),
    .blk1_hoffset_i      (h[0]),
    .blk2_hoffset_i      (h[1]),
    .blk3_hoffset_i      (h[2]),
    .blk4_hoffset_i      (h[3]),
    .board_rd_en_o       (board_rd_en),
    .board_rd_row_o      (board_rd_row),
    .board_rd_col_o      (board_rd_col),
    .board_rd_occupied_i (occ_q),
    .pos_row_o           (pos_row),
    .pos_col_o           (pos_col),
    .rot_o               (rot),
    .piece_type_o        (piece_type),
    .piece_active_o      (piece_active),
    .lock_valid_o        (lock_valid),
    .game_over_o         (game_over),
    .busy_o              (busy)
  );

  always @(posedge clk) begin
    if (board_rd_en && board_rd_row < 5'd20 && board_rd_col < 4'd10)
      occ_q <= board[board_rd_row][board_rd_col];
    else
      occ_q <= 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        board[r][c] = 1'b0;
  endtask

  task automatic set_o_piece();
    v[0] = 5'd0; v[1] = 5'd0; v[2] = 5'd1; v[3] = 5'd1;
    h[0] = 5'd0; h[1] = 5'd1; h[2] = 5'd0; h[3] = 5'd1;
  endtask

  // Issue one request and follow it through RES and the exit edge.
  task automatic do_cmd(input bit is_spawn, input logic [2:0] typ, input logic [1:0] c, input bit pulse);
    int n;
    if (is_spawn) begin mv.spawn_valid = 1'b1; mv.spawn_type = typ; end
    else begin mv.cmd_valid = 1'b1; mv.cmd = c; end
    tick();
    mv.spawn_valid = 1'b0;
    mv.cmd_valid   = 1'b0;
    n = 0; rd_cnt = 0; bad_rd = 0; lock_cnt = 0; ready_seen = 0;
    while (mv.cmd_done !== 1'b1 && n < 20) begin
      if (pulse && n == 3) begin mv.cmd_valid = 1'b1; mv.cmd = 2'b01; end
      if (pulse && n == 6) mv.cmd_valid = 1'b0;
      tick();
      n++;
      if (mv.cmd_ready === 1'b1) ready_seen = 1;
      if (board_rd_en === 1'b1) begin
        rd_cnt++;
        if (board_rd_col > 4'd9) bad_rd++;
      end
      if (lock_valid === 1'b1) lock_cnt++;
    end
    mv.cmd_valid = 1'b0;
    lat = n;
    r_ok = mv.cmd_ok;
    r_lock = lock_valid;
    r_pos_row = pos_row;
    r_sh_type = shaper_type;
    r_sh_rot = shaper_rotation;
    tick();
    if (lock_valid === 1'b1) lock_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (pos_row !== 5'd0) begin n_err++; $display("FAIL reset_pos_row got %0d want 0", pos_row); end
    n_cmp++; if (pos_col !== 4'd0) begin n_err++; $display("FAIL reset_pos_col got %0d want 0", pos_col); end
    n_cmp++; if (piece_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", piece_active); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mv.spawn_ready !== 1'b0) begin n_err++; $display("FAIL reset_spawn_ready_held got %b want 0", mv.spawn_ready); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (mv.spawn_ready !== 1'b1) begin n_err++; $display("FAIL reset_spawn_ready got %b want 1", mv.spawn_ready); end
    n_cmp++; if (mv.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready got %b want 0", mv.cmd_ready); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over got %b want 0", game_over); end
  endtask

  task automatic test_spawn();
    mv.cmd_valid = 1'b1;
    mv.cmd = 2'b01;
    do_cmd(1'b1, 3'd3, 2'b00, 1'b0);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL spawn_latency got %0d want 10", lat); end
    n_cmp++; if (r_ok !== 1'b1) begin n_err++; $display("FAIL spawn_ok got %b want 1", r_ok); end
    n_cmp++; if (rd_cnt !== 4) begin n_err++; $display("FAIL spawn_reads got %0d want 4", rd_cnt); end
    n_cmp++; if (r_sh_type !== 3'd3) begin n_err++; $display("FAIL spawn_shaper_type got %0d want 3", r_sh_type); end
    n_cmp++; if (pos_row !== 5'd0 || pos_col !== 4'd4) begin n_err++; $display("FAIL spawn_pos got (%0d,%0d) want (0,4)", pos_row, pos_col); end
    n_cmp++; if (rot !== 3'd0 || piece_type !== 3'd3) begin n_err++; $display("FAIL spawn_rot_type got %0d/%0d want 0/3", rot, piece_type); end
    n_cmp++; if (piece_active !== 1'b1 || mv.cmd_ready !== 1'b1) begin n_err++; $display("FAIL spawn_active got %b ready %b want 1 1", piece_active, mv.cmd_ready); end
    n_cmp++; if (mv.spawn_ready !== 1'b0) begin n_err++; $display("FAIL spawn_ready_after got %b want 0", mv.spawn_ready); end
  endtask

  task automatic test_move();
    do_cmd(1'b0, 3'd0, 2'b01, 1'b0);
    n_cmp++; if (pos_col !== 4'd5 || r_ok !== 1'b1) begin n_err++; $display("FAIL move_right got col %0d ok %b want 5 1", pos_col, r_ok); end
    do_cmd(1'b0, 3'd0, 2'b10, 1'b0);
    n_cmp++; if (rot !== 3'd1 || r_sh_rot !== 3'd1) begin n_err++; $display("FAIL move_rotate got rot %0d shaper %0d want 1 1", rot, r_sh_rot); end
    do_cmd(1'b0, 3'd0, 2'b11, 1'b0);
    n_cmp++; if (pos_row !== 5'd1 || lock_cnt !== 0) begin n_err++; $display("FAIL move_down got row %0d locks %0d want 1 0", pos_row, lock_cnt); end
    do_cmd(1'b0, 3'd0, 2'b00, 1'b0);
    n_cmp++; if (pos_col !== 4'd4) begin n_err++; $display("FAIL move_left got col %0d want 4", pos_col); end
    board[1][6] = 1'b1;
    do_cmd(1'b0, 3'd0, 2'b01, 1'b0);
    n_cmp++; if (r_ok !== 1'b0 || pos_col !== 4'd4) begin n_err++; $display("FAIL move_blocked got ok %b col %0d want 0 4", r_ok, pos_col); end
    n_cmp++; if (lock_cnt !== 0 || piece_active !== 1'b1) begin n_err++; $display("FAIL move_blocked_lock got locks %0d active %b want 0 1", lock_cnt, piece_active); end
    board[1][6] = 1'b0;
  endtask

  task automatic test_rotate_wrap();
    do_cmd(1'b0, 3'd0, 2'b10, 1'b0);
    do_cmd(1'b0, 3'd0, 2'b10, 1'b0);
    n_cmp++; if (rot !== 3'd3) begin n_err++; $display("FAIL rot_to3 got %0d want 3", rot); end
    do_cmd(1'b0, 3'd0, 2'b10, 1'b1);
    n_cmp++; if (rot !== 3'd0 || r_sh_rot !== 3'd0) begin n_err++; $display("FAIL rot_wrap got rot %0d shaper %0d want 0 0", rot, r_sh_rot); end
    n_cmp++; if (ready_seen !== 1'b0) begin n_err++; $display("FAIL busy_cmd_ready got %b want 0", ready_seen); end
    n_cmp++; if (pos_col !== 4'd4 || busy !== 1'b0) begin n_err++; $display("FAIL busy_pulse_ignored got col %0d busy %b want 4 0", pos_col, busy); end
  endtask

  task automatic test_left_wall();
    for (int i = 0; i < 4; i++) do_cmd(1'b0, 3'd0, 2'b00, 1'b0);
    n_cmp++; if (pos_col !== 4'd0) begin n_err++; $display("FAIL wall_reach got col %0d want 0", pos_col); end
    h[0] = 5'd0; h[1] = 5'd1; h[2] = 5'd1; h[3] = 5'd0;
    do_cmd(1'b0, 3'd0, 2'b00, 1'b0);
    n_cmp++; if (r_ok !== 1'b0 || lat !== 10) begin n_err++; $display("FAIL wall_ok got ok %b lat %0d want 0 10", r_ok, lat); end
    n_cmp++; if (rd_cnt !== 2 || bad_rd !== 0) begin n_err++; $display("FAIL wall_reads got %0d bad %0d want 2 0", rd_cnt, bad_rd); end
    n_cmp++; if (pos_col !== 4'd0) begin n_err++; $display("FAIL wall_col got %0d want 0", pos_col); end
    set_o_piece();
  endtask

  task automatic test_down_lock();
    int fails;
    fails = 0;
    for (int i = 0; i < 17; i++) begin
      do_cmd(1'b0, 3'd0, 2'b11, 1'b0);
      if (r_ok !== 1'b1) fails++;
    end
    n_cmp++; if (fails !== 0 || pos_row !== 5'd18) begin n_err++; $display("FAIL descend got row %0d fails %0d want 18 0", pos_row, fails); end
    do_cmd(1'b0, 3'd0, 2'b11, 1'b0);
    n_cmp++; if (r_ok !== 1'b0 || r_lock !== 1'b1) begin n_err++; $display("FAIL lock_res got ok %b lock %b want 0 1", r_ok, r_lock); end
    n_cmp++; if (r_pos_row !== 5'd18 || pos_row !== 5'd18) begin n_err++; $display("FAIL lock_row got %0d/%0d want 18", r_pos_row, pos_row); end
    n_cmp++; if (lock_cnt !== 1) begin n_err++; $display("FAIL lock_pulses got %0d want 1", lock_cnt); end
    n_cmp++; if (piece_active !== 1'b0 || mv.spawn_ready !== 1'b1) begin n_err++; $display("FAIL lock_active got %b ready %b want 0 1", piece_active, mv.spawn_ready); end
  endtask

  task automatic test_game_over();
    board[0][4] = 1'b1;
    do_cmd(1'b1, 3'd2, 2'b00, 1'b0);
    n_cmp++; if (r_ok !== 1'b0 || lat !== 10) begin n_err++; $display("FAIL go_ok got ok %b lat %0d want 0 10", r_ok, lat); end
    n_cmp++; if (game_over !== 1'b1 || piece_active !== 1'b0) begin n_err++; $display("FAIL go_flag got %b active %b want 1 0", game_over, piece_active); end
    n_cmp++; if (mv.spawn_ready !== 1'b0) begin n_err++; $display("FAIL go_spawn_ready got %b want 0", mv.spawn_ready); end
    mv.spawn_valid = 1'b1;
    mv.spawn_type = 3'd1;
    tick();
    mv.spawn_valid = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || game_over !== 1'b1) begin n_err++; $display("FAIL go_spawn_ignored got busy %b go %b want 0 1", busy, game_over); end
  endtask

  task automatic test_reset_midflight();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_board();
    n_cmp++; if (game_over !== 1'b0 || mv.spawn_ready !== 1'b1) begin n_err++; $display("FAIL rst2_clear got go %b ready %b want 0 1", game_over, mv.spawn_ready); end
    do_cmd(1'b1, 3'd5, 2'b00, 1'b0);
    board[1][4] = 1'b1;
    mv.cmd_valid = 1'b1;
    mv.cmd = 2'b11;
    tick();
    mv.cmd_valid = 1'b0;
    repeat (7) tick();
    n_cmp++; if (busy !== 1'b1 || board_rd_en !== 1'b0) begin n_err++; $display("FAIL midflight_busy got busy %b rd %b want 1 0", busy, board_rd_en); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || mv.cmd_done !== 1'b0 || lock_valid !== 1'b0) begin n_err++; $display("FAIL midflight_rst_ctrl got busy %b done %b lock %b want 0", busy, mv.cmd_done, lock_valid); end
    n_cmp++; if (pos_col !== 4'd0 || piece_type !== 3'd0 || piece_active !== 1'b0) begin n_err++; $display("FAIL midflight_rst_state got col %0d type %0d act %b want 0", pos_col, piece_type, piece_active); end
    n_cmp++; if (mv.spawn_ready !== 1'b0 || mv.cmd_ready !== 1'b0 || shaper_type !== 3'd0) begin n_err++; $display("FAIL midflight_rst_out got sr %b cr %b sh %0d want 0", mv.spawn_ready, mv.cmd_ready, shaper_type); end
    begin
      int lk;
      lk = 0;
      repeat (3) begin tick(); if (lock_valid === 1'b1) lk++; end
      rst_n = 1'b1;
      repeat (4) begin tick(); if (lock_valid === 1'b1 || mv.cmd_done === 1'b1) lk++; end
      n_cmp++; if (lk !== 0) begin n_err++; $display("FAIL midflight_no_lock got %0d want 0", lk); end
    end
    n_cmp++; if (busy !== 1'b0 || mv.spawn_ready !== 1'b1) begin n_err++; $display("FAIL midflight_idle got busy %b ready %b want 0 1", busy, mv.spawn_ready); end
  endtask

  initial begin
    mv.spawn_valid = 1'b0;
    mv.spawn_type  = 3'd0;
    mv.cmd_valid   = 1'b0;
    mv.cmd         = 2'b00;
    set_o_piece();
    clear_board();
    test_reset();
    test_spawn();
    test_move();
    test_rotate_wrap();
    test_left_wall();
    test_down_lock();
    test_game_over();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
